// File: rtl/alu_pipe.sv
// Pipelined integer execute unit: single-cycle ALU feeding a p_stages-deep
// result pipeline with valid/ready flow control and collapsing bubbles.
module alu_pipe #(
  parameter int p_stages       = 2,
  parameter int p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  // issue side
  input  logic                      d_val,
  output logic                      d_rdy,
  input  logic [31:0]               d_pc,
  input  logic [p_seq_num_bits-1:0] d_seq_num,
  input  logic [31:0]               d_op1,
  input  logic [31:0]               d_op2,
  input  logic [4:0]                d_waddr,
  input  logic [3:0]                d_uop,
  // writeback side
  output logic                      w_val,
  input  logic                      w_rdy,
  output logic [31:0]               w_pc,
  output logic [p_seq_num_bits-1:0] w_seq_num,
  output logic [4:0]                w_waddr,
  output logic [31:0]               w_wdata,
  output logic                      w_wen
);

  // Handshake: a transfer happens on a rising edge where val & rdy are both 1;
  // a source holding val=1 keeps its payload stable until that edge, and
  // d_rdy may depend combinationally on w_rdy.

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_LUI  = 4'd10;

  typedef struct packed {
    logic [31:0]               pc;
    logic [p_seq_num_bits-1:0] seq_num;
    logic [4:0]                waddr;
    logic                      wen;
    logic [31:0]               result;
  } stage_t;

  stage_t              stg_q [p_stages];
  logic [p_stages-1:0] val_q;
  logic [p_stages-1:0] free;
  stage_t              issue;
  logic                any_empty;
  logic [4:0]          shamt;

  assign shamt = d_op2[4:0];

  always_comb begin
    issue.pc      = d_pc;
    issue.seq_num = d_seq_num;
    issue.waddr   = d_waddr;
    issue.wen     = 1'b1;
    issue.result  = 32'h0;
    case (d_uop)
      OP_ADD:  issue.result = d_op1 + d_op2;
      OP_SUB:  issue.result = d_op1 - d_op2;
      OP_AND:  issue.result = d_op1 & d_op2;
      OP_OR:   issue.result = d_op1 | d_op2;
      OP_XOR:  issue.result = d_op1 ^ d_op2;
      OP_SLT:  issue.result = {31'd0, $signed(d_op1) < $signed(d_op2)};
      OP_SLTU: issue.result = {31'd0, d_op1 < d_op2};
      OP_SLL:  issue.result = d_op1 << shamt;
      OP_SRL:  issue.result = d_op1 >> shamt;
      OP_SRA:  issue.result = $unsigned($signed(d_op1) >>> shamt);
      OP_LUI:  issue.result = d_op2;
      default: issue.wen    = 1'b0;
    endcase
  end

  // Stage k may load when it or any stage after it is empty, or the tail is
  // draining; this makes bubbles collapse regardless of w_rdy.
  always_comb begin
    free      = '0;
    any_empty = w_rdy;
    for (int k = p_stages - 1; k >= 0; k--) begin
      any_empty = any_empty | !val_q[k];
      free[k]   = any_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
    end else begin
      if (free[0]) val_q[0] <= d_val;
      for (int k = 1; k < p_stages; k++) begin
        if (free[k]) val_q[k] <= val_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (free[0]) stg_q[0] <= issue;
    for (int k = 1; k < p_stages; k++) begin
      if (free[k]) stg_q[k] <= stg_q[k-1];
    end
  end

  assign d_rdy     = free[0];
  assign w_val     = val_q[p_stages-1];
  assign w_pc      = stg_q[p_stages-1].pc;
  assign w_seq_num = stg_q[p_stages-1].seq_num;
  assign w_waddr   = stg_q[p_stages-1].waddr;
  assign w_wdata   = stg_q[p_stages-1].result;
  assign w_wen     = stg_q[p_stages-1].wen;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: three instances (depth 2, 3, 1) share the issue stream;
// each has its own expected queue, plus directed checks on latency and stalls.
module tb_alu_pipe;

  localparam int W = 75;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_LUI  = 4'd10;
  localparam logic [3:0] OP_BAD  = 4'd15;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        d_val, w_rdy;
  logic [31:0] d_pc, d_op1, d_op2;
  logic [4:0]  d_seq_num, d_waddr;
  logic [3:0]  d_uop;

  logic        d_rdy_v   [3];
  logic        w_val_v   [3];
  logic        w_wen_v   [3];
  logic [31:0] w_pc_v    [3];
  logic [31:0] w_wdata_v [3];
  logic [4:0]  w_seq_v   [3];
  logic [4:0]  w_waddr_v [3];

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q [3][$];

  // index 0: depth 2, index 1: depth 3, index 2: depth 1
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int ps = (g == 0) ? 2 : ((g == 1) ? 3 : 1);
    alu_pipe #(.p_stages(ps), .p_seq_num_bits(5)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .d_val     (d_val),
      .d_rdy     (d_rdy_v[g]),
      .d_pc      (d_pc),
      .d_seq_num (d_seq_num),
      .d_op1     (d_op1),
      .d_op2     (d_op2),
      .d_waddr   (d_waddr),
      .d_uop     (d_uop),
      .w_val     (w_val_v[g]),
      .w_rdy     (w_rdy),
      .w_pc      (w_pc_v[g]),
      .w_seq_num (w_seq_v[g]),
      .w_waddr   (w_waddr_v[g]),
      .w_wdata   (w_wdata_v[g]),
      .w_wen     (w_wen_v[g])
    );
  end

  function automatic logic [32:0] model(input logic [3:0] u, input logic [31:0] a, input logic [31:0] b);
    case (u)
      OP_ADD:  return {1'b1, a + b};
      OP_SUB:  return {1'b1, a - b};
      OP_AND:  return {1'b1, a & b};
      OP_OR:   return {1'b1, a | b};
      OP_XOR:  return {1'b1, a ^ b};
      OP_SLT:  return {1'b1, 31'd0, $signed(a) < $signed(b)};
      OP_SLTU: return {1'b1, 31'd0, a < b};
      OP_SLL:  return {1'b1, a << b[4:0]};
      OP_SRL:  return {1'b1, a >> b[4:0]};
      OP_SRA:  return {1'b1, $unsigned($signed(a) >>> b[4:0])};
      OP_LUI:  return {1'b1, b};
      default: return {1'b0, 32'h0};
    endcase
  endfunction

  function automatic logic [W-1:0] exp_pkt();
    return {d_pc, d_seq_num, d_waddr, model(d_uop, d_op1, d_op2)};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] u, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] s, input logic [4:0] wa);
    d_val     = 1'b1;
    d_uop     = u;
    d_op1     = a;
    d_op2     = b;
    d_seq_num = s;
    d_waddr   = wa;
    d_pc      = $urandom;
  endtask

  // scoreboard: inputs are stable at the falling edge, so transfers about to
  // happen on the next rising edge are observed here
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        exp_q[i].delete();
      end else begin
        if (w_val_v[i] && w_rdy) begin
          if (exp_q[i].size() == 0)
            chk($sformatf("w_extra_%0d", i), W'(w_val_v[i]), W'(0));
          else
            chk($sformatf("w_pkt_%0d", i),
                {w_pc_v[i], w_seq_v[i], w_waddr_v[i], w_wen_v[i], w_wdata_v[i]},
                exp_q[i].pop_front());
        end
        if (d_val && d_rdy_v[i]) exp_q[i].push_back(exp_pkt());
      end
    end
  end

  initial begin
    rst = 1'b1; d_val = 1'b0; w_rdy = 1'b1;
    d_pc = '0; d_op1 = '0; d_op2 = '0; d_seq_num = '0; d_waddr = '0; d_uop = '0;
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_wval_%0d", i), W'(w_val_v[i]), W'(0));
      chk($sformatf("rst_drdy_%0d", i), W'(d_rdy_v[i]), W'(1));
    end

    // latency: ADD 5,7 seq 3 on depth 2
    issue(OP_ADD, 32'd5, 32'd7, 5'd3, 5'd1);
    step();
    d_val = 1'b0;
    chk("lat_early_wval", W'(w_val_v[0]), W'(0));
    step();
    chk("lat_wval",  W'(w_val_v[0]),   W'(1));
    chk("lat_wdata", W'(w_wdata_v[0]), W'(32'd12));
    chk("lat_wen",   W'(w_wen_v[0]),   W'(1));
    chk("lat_seq",   W'(w_seq_v[0]),   W'(5'd3));
    repeat (4) step();

    // op sweep, back to back; depth 1 shows each result one cycle later
    issue(OP_SUB, 32'd3, 32'd5, 5'd4, 5'd2); step();
    chk("sub", W'(w_wdata_v[2]), W'(32'hFFFF_FFFE));
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd5, 5'd3); step();
    chk("slt", W'(w_wdata_v[2]), W'(32'h1));
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd6, 5'd4); step();
    chk("sltu", W'(w_wdata_v[2]), W'(32'h0));
    issue(OP_SRA, 32'h8000_0000, 32'd33, 5'd7, 5'd5); step();
    chk("sra", W'(w_wdata_v[2]), W'(32'hC000_0000));
    issue(OP_LUI, 32'hDEAD_BEEF, 32'h1234_5000, 5'd8, 5'd6); step();
    chk("lui", W'(w_wdata_v[2]), W'(32'h1234_5000));
    issue(OP_SRL, 32'h8000_0000, 32'hFFFF_FFE4, 5'd9, 5'd7); step();
    chk("srl", W'(w_wdata_v[2]), W'(32'h0800_0000));
    issue(OP_SLL, 32'h0000_0003, 32'd31, 5'd10, 5'd8); step();
    chk("sll", W'(w_wdata_v[2]), W'(32'h8000_0000));
    issue(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd11, 5'd9); step();
    chk("xor", W'(w_wdata_v[2]), W'(32'h0FF0_0FF0));
    issue(OP_ADD, 32'hFFFF_FFFF, 32'd2, 5'd12, 5'd10); step();
    chk("add_wrap", W'(w_wdata_v[2]), W'(32'h1));
    d_val = 1'b0;
    repeat (5) step();

    // full stall on depth 3: seq 1,2,3 with w_rdy low
    w_rdy = 1'b0;
    for (int s = 1; s <= 3; s++) begin
      issue(OP_OR, 32'(s), 32'h100, 5'(s), 5'(s)); step();
    end
    d_val = 1'b0;
    chk("full_drdy_3", W'(d_rdy_v[1]), W'(0));
    chk("full_drdy_2", W'(d_rdy_v[0]), W'(0));
    chk("full_drdy_1", W'(d_rdy_v[2]), W'(0));
    repeat (2) step();
    chk("full_hold_val", W'(w_val_v[1]), W'(1));
    chk("full_hold_seq", W'(w_seq_v[1]), W'(5'd1));
    w_rdy = 1'b1;
    step();
    chk("drain_seq2", W'({w_val_v[1], w_seq_v[1]}), W'({1'b1, 5'd2}));
    step();
    chk("drain_seq3", W'({w_val_v[1], w_seq_v[1]}), W'({1'b1, 5'd3}));
    repeat (4) step();

    // bubble collapse on depth 3 while w_rdy is low
    w_rdy = 1'b0;
    issue(OP_AND, 32'hFF, 32'h0F, 5'd1, 5'd11); step();
    chk("bub_drdy_a", W'(d_rdy_v[1]), W'(1));
    d_val = 1'b0; step();
    chk("bub_drdy_b", W'(d_rdy_v[1]), W'(1));
    issue(OP_AND, 32'hF0, 32'h3C, 5'd2, 5'd12); step();
    chk("bub_drdy_c", W'(d_rdy_v[1]), W'(1));
    chk("bub_head",   W'({w_val_v[1], w_seq_v[1]}), W'({1'b1, 5'd1}));
    issue(OP_AND, 32'h1, 32'h1, 5'd3, 5'd13); step();
    d_val = 1'b0;
    chk("bub_drdy_full", W'(d_rdy_v[1]), W'(0));
    w_rdy = 1'b1;
    repeat (5) step();

    // reset with work in flight
    issue(OP_ADD, 32'd1, 32'd1, 5'd20, 5'd14); step();
    issue(OP_ADD, 32'd2, 32'd2, 5'd21, 5'd15); step();
    d_val = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mid_rst_wval_%0d", i), W'(w_val_v[i]), W'(0));
      chk($sformatf("mid_rst_drdy_%0d", i), W'(d_rdy_v[i]), W'(1));
    end
    repeat (4) begin
      step();
      for (int i = 0; i < 3; i++) chk($sformatf("post_rst_wval_%0d", i), W'(w_val_v[i]), W'(0));
    end

    // illegal uop on depth 2
    issue(OP_BAD, 32'h1234, 32'h5678, 5'd9, 5'd7); step();
    d_val = 1'b0; step();
    chk("bad_wval",  W'(w_val_v[0]),   W'(1));
    chk("bad_wen",   W'(w_wen_v[0]),   W'(0));
    chk("bad_wdata", W'(w_wdata_v[0]), W'(0));
    chk("bad_seq",   W'(w_seq_v[0]),   W'(5'd9));
    chk("bad_waddr", W'(w_waddr_v[0]), W'(5'd7));
    repeat (3) step();

    // random traffic with random back-pressure
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) != 0)
        issue(4'($urandom_range(0, 15)), $urandom, $urandom, 5'(n), 5'($urandom_range(0, 31)));
      else
        d_val = 1'b0;
      w_rdy = ($urandom_range(0, 2) != 0);
      step();
    end
    d_val = 1'b0; w_rdy = 1'b1;
    repeat (10) step();
    for (int i = 0; i < 3; i++) chk($sformatf("final_q_empty_%0d", i), W'(exp_q[i].size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
